// File: rtl/swdb_pkg.sv
// Shared types and default constants for the switch debouncer.
// The optional event counter is enabled with SWITCH_DEBOUNCER_EVENT_CNT_EN.
package swdb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } swdb_state_e;

  localparam int         SWDB_WIDTH         = 5;
  localparam int         SWDB_STABLE_CYCLES = 1000000;
  localparam logic [4:0] SWDB_RESET_VAL     = 5'h0F;
  localparam int         SWDB_EVENT_CNT_W   = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a vector of asynchronous levels.
// Both stages reset to RESET_VAL so the downstream logic sees a known word.
module sync_2ff #(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_d, sync1_q;
  logic [WIDTH-1:0] sync2_d, sync2_q;

  // Shift the raw input through two stages to settle metastability.
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  // Synchroniser registers, reset to the idle pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/switch_debouncer.sv
// Whole-vector switch debouncer feeding the combination-lock FSM.
// A new word is accepted only after the synchronised vector has held
// unchanged for STABLE_CYCLES cycles; partial codes are never emitted.
// Optional: define SWITCH_DEBOUNCER_EVENT_CNT_EN to add o_event_cnt, a
// saturating count of accepted changes.
module switch_debouncer
  import swdb_pkg::*;
#(
  parameter int               WIDTH         = SWDB_WIDTH,
  parameter int               STABLE_CYCLES = SWDB_STABLE_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VAL     = WIDTH'(SWDB_RESET_VAL)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_switch,
  output logic [WIDTH-1:0] o_switch,
  output logic             o_change
`ifdef SWITCH_DEBOUNCER_EVENT_CNT_EN
  ,
  output logic [SWDB_EVENT_CNT_W-1:0] o_event_cnt
`endif
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_w;

  swdb_state_e      state_d, state_q;
  logic [WIDTH-1:0] cand_d, cand_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] switch_d, switch_q;
  logic             change_d, change_q;

  sync_2ff #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_switch),
    .q   (sync_w)
  );

  // Next-state logic: track a candidate word and accept it once it has held.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    switch_d = switch_q;
    change_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_w != switch_q) begin
          cand_d  = sync_w;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (sync_w == switch_q) begin
          state_d = IDLE;
        end else if (sync_w != cand_q) begin
          cand_d = sync_w;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          switch_d = cand_q;
          change_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Debounce state registers; reset discards any pending candidate.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cand_q   <= RESET_VAL;
      cnt_q    <= '0;
      switch_q <= RESET_VAL;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      switch_q <= switch_d;
      change_q <= change_d;
    end
  end

  assign o_switch = switch_q;
  assign o_change = change_q;

`ifdef SWITCH_DEBOUNCER_EVENT_CNT_EN
  logic [SWDB_EVENT_CNT_W-1:0] evt_d, evt_q;

  // Count accepted changes, holding at all-ones instead of wrapping.
  always_comb begin
    evt_d = evt_q;
    if (change_d && (evt_q != '1)) begin
      evt_d = evt_q + SWDB_EVENT_CNT_W'(1);
    end
  end

  // Event counter register, updated together with o_change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign o_event_cnt = evt_q;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with STABLE_CYCLES=4, WIDTH=5.
// Stimulus pushes the expected accepted word and its acceptance cycle;
// a monitor pops and compares whenever o_switch changes or o_change pulses.
module tb_switch_debouncer;

  localparam int         WIDTH  = 5;
  localparam int         STABLE = 4;
  localparam int         LAT    = STABLE + 3;
  localparam logic [4:0] RVAL   = 5'h0F;

  typedef struct {
    logic [WIDTH-1:0] val;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] i_switch = RVAL;
  logic [WIDTH-1:0] o_switch;
  logic             o_change;
`ifdef SWITCH_DEBOUNCER_EVENT_CNT_EN
  logic [7:0]       o_event_cnt;
`endif

  exp_t             sb_q[$];
  int               cyc = 0;
  int               pass_cnt = 0;
  int               total_cnt = 0;
  logic [WIDTH-1:0] prev_sw = RVAL;

  switch_debouncer #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE),
    .RESET_VAL     (RVAL)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_switch (i_switch),
    .o_switch (o_switch),
    .o_change (o_change)
`ifdef SWITCH_DEBOUNCER_EVENT_CNT_EN
    ,
    .o_event_cnt (o_event_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

  // Drive a new raw level on the falling edge; optionally expect acceptance.
  task automatic applyStimulus(input logic [WIDTH-1:0] val, input bit accept);
    @(negedge clk);
    i_switch = val;
    if (accept) sb_q.push_back('{val, cyc + LAT});
  endtask

  task automatic holdCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any visible output event must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_sw = o_switch;
    end else begin
      if (o_change || (o_switch != prev_sw)) begin
        total_cnt++;
        if (sb_q.size() == 0) begin
          $display("[TB] FAIL unexpected_event: cyc %0d o_switch 0x%0h o_change %0b, none expected",
                   cyc, o_switch, o_change);
        end else begin
          e = sb_q.pop_front();
          if (o_change && (o_switch == e.val) && (cyc == e.cyc)) pass_cnt++;
          else $display("[TB] FAIL accept: got 0x%0h chg %0b at cyc %0d, want 0x%0h chg 1 at cyc %0d",
                        o_switch, o_change, cyc, e.val, e.cyc);
        end
      end
      prev_sw = o_switch;
    end
  end

  initial begin
    // Power-on reset
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_switch", int'(o_switch), 32'h0F);
    checkOutput("reset_change", int'(o_change), 0);
    holdCycles(3);
    rst = 1'b0;

    // Quiet input stays at the idle pattern
    holdCycles(10);
    checkOutput("idle_hold", int'(o_switch), 32'h0F);

    // Clean step and return
    applyStimulus(5'h0E, 1'b1);
    holdCycles(12);
    checkOutput("clean_step", int'(o_switch), 32'h0E);
    applyStimulus(5'h0F, 1'b1);
    holdCycles(12);

    // Bounce: ten single-cycle toggles, then settle on 0E
    for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 5'h0E : 5'h0F, 1'b0);
    applyStimulus(5'h0E, 1'b1);
    holdCycles(12);
    checkOutput("bounce_settle", int'(o_switch), 32'h0E);
    applyStimulus(5'h0F, 1'b1);
    holdCycles(12);

    // Glitch shorter than the acceptance window
    applyStimulus(5'h0D, 1'b0);
    holdCycles(2);
    applyStimulus(5'h0F, 1'b0);
    holdCycles(12);
    checkOutput("glitch_reject", int'(o_switch), 32'h0F);

    // Staggered bits: 0B must never be emitted
    applyStimulus(5'h0B, 1'b0);
    applyStimulus(5'h07, 1'b1);
    holdCycles(12);
    checkOutput("staggered", int'(o_switch), 32'h07);

    // Reset in the middle of a count
    applyStimulus(5'h1F, 1'b0);
    holdCycles(3);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_switch", int'(o_switch), 32'h0F);
    checkOutput("midreset_change", int'(o_change), 0);
    holdCycles(2);
    rst = 1'b0;
    sb_q.push_back('{5'h1F, cyc + LAT});
    holdCycles(12);
    checkOutput("post_reset", int'(o_switch), 32'h1F);

`ifdef SWITCH_DEBOUNCER_EVENT_CNT_EN
    checkOutput("evt_one", int'(o_event_cnt), 1);
    for (int k = 0; k < 300; k++) begin
      applyStimulus((k % 2 == 0) ? 5'h0F : 5'h1F, 1'b1);
      holdCycles(LAT);
    end
    holdCycles(10);
    checkOutput("evt_saturate", int'(o_event_cnt), 32'hFF);
`endif

    holdCycles(2);
    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
